// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The KEYPAD_AUTOREPEAT_EN build uses the repeat multipliers below.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } kp_state_e;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] COL_RESET         = 4'b1110;
    localparam int         REPEAT_FIRST_MULT = 8;
    localparam int         REPEAT_NEXT_MULT  = 2;

    function automatic logic one_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        case (rows)
            4'b1110: low_row_idx = 2'd0;
            4'b1101: low_row_idx = 2'd1;
            4'b1011: low_row_idx = 2'd2;
            4'b0111: low_row_idx = 2'd3;
            default: low_row_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta_r;
    logic [3:0] sync_r;

    // Two-stage capture; idle (pulled-up) rows read as all ones after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 4'b1111;
            sync_r <= 4'b1111;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column rotation, debounce, release tracking and a
// held-until-ack key event. Define KEYPAD_AUTOREPEAT_EN for held-key repeat.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS   = 10000,
    parameter int STABLE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output key_code_t  key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_pressed,
    output logic       overrun
);
    localparam int SLOT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(STABLE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_SCANS - 1);

    kp_state_e         state_r, state_s;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [1:0]        col_idx_r, col_idx_s;
    logic [1:0]        cand_row_r, cand_row_s;
    logic [CNT_W-1:0]  match_cnt_r, match_cnt_s;
    logic [3:0]        rows_s, cand_rows_s, col_out_r;
    logic              sample_s, accept_s, release_s, event_s;
    key_code_t         key_code_r;
    logic              key_valid_r, key_pressed_r, overrun_r;

    row_sync u_row_sync (.clk(clk), .rst(rst), .d(row_in), .q(rows_s));

    assign sample_s    = (slot_cnt_r == SLOT_LAST);
    assign cand_rows_s = ~(4'b0001 << cand_row_r);

    // Slot timer; its last count is the single sample point of each slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          slot_cnt_r <= '0;
        else if (sample_s) slot_cnt_r <= '0;
        else               slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
    end

    // Scan/debounce/release decisions; the column only moves when a slot is abandoned.
    always_comb begin
        state_s     = state_r;
        col_idx_s   = col_idx_r;
        cand_row_s  = cand_row_r;
        match_cnt_s = match_cnt_r;
        accept_s    = 1'b0;
        release_s   = 1'b0;
        if (sample_s) begin
            case (state_r)
                SCAN: begin
                    if (one_low(rows_s)) begin
                        cand_row_s  = low_row_idx(rows_s);
                        match_cnt_s = CNT_W'(1);
                        state_s     = DEBOUNCE;
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != cand_rows_s) begin
                        state_s   = SCAN;
                        col_idx_s = col_idx_r + 2'd1;
                    end else if (match_cnt_r >= CNT_LAST) begin
                        accept_s    = 1'b1;
                        match_cnt_s = '0;
                        state_s     = RELEASE;
                    end else begin
                        match_cnt_s = match_cnt_r + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (rows_s != 4'b1111) begin
                        match_cnt_s = '0;
                    end else if (match_cnt_r >= CNT_LAST) begin
                        release_s   = 1'b1;
                        match_cnt_s = '0;
                        state_s     = SCAN;
                        col_idx_s   = col_idx_r + 2'd1;
                    end else begin
                        match_cnt_s = match_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s     = SCAN;
                    match_cnt_s = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_FIRST_MULT * STABLE_SCANS + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(REPEAT_FIRST_MULT * STABLE_SCANS - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT_LAST  = RPT_W'(REPEAT_NEXT_MULT * STABLE_SCANS - 1);

    logic [RPT_W-1:0] rpt_cnt_r, rpt_cnt_s;
    logic             rpt_fast_r, rpt_fast_s, repeat_s;

    // Repeat timer: counts consecutive held samples; any break restarts the long delay.
    always_comb begin
        rpt_cnt_s  = rpt_cnt_r;
        rpt_fast_s = rpt_fast_r;
        repeat_s   = 1'b0;
        if (sample_s && state_r == RELEASE && rows_s == cand_rows_s) begin
            if (rpt_cnt_r >= (rpt_fast_r ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
                repeat_s   = 1'b1;
                rpt_cnt_s  = '0;
                rpt_fast_s = 1'b1;
            end else begin
                rpt_cnt_s = rpt_cnt_r + RPT_W'(1);
            end
        end else if (sample_s || state_r != RELEASE) begin
            rpt_cnt_s  = '0;
            rpt_fast_s = 1'b0;
        end else begin
            rpt_cnt_s = rpt_cnt_r;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_r  <= '0;
            rpt_fast_r <= 1'b0;
        end else begin
            rpt_cnt_r  <= rpt_cnt_s;
            rpt_fast_r <= rpt_fast_s;
        end
    end

    assign event_s = accept_s | repeat_s;
`else
    assign event_s = accept_s;
`endif

    // FSM, column and candidate registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= SCAN;
            col_idx_r   <= 2'd0;
            col_out_r   <= COL_RESET;
            cand_row_r  <= 2'd0;
            match_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            col_idx_r   <= col_idx_s;
            col_out_r   <= ~(4'b0001 << col_idx_s);
            cand_row_r  <= cand_row_s;
            match_cnt_r <= match_cnt_s;
        end
    end

    // Key event handshake: an ack on the acceptance cycle frees the slot for the new code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code_r    <= 4'h0;
            key_valid_r   <= 1'b0;
            key_pressed_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            if (event_s && (!key_valid_r || key_ack)) begin
                key_code_r  <= {col_idx_r, cand_row_r};
                key_valid_r <= 1'b1;
            end else if (event_s) begin
                overrun_r <= 1'b1;
            end else if (key_ack) begin
                key_valid_r <= 1'b0;
            end else begin
                key_valid_r <= key_valid_r;
            end
            if (event_s)        key_pressed_r <= 1'b1;
            else if (release_s) key_pressed_r <= 1'b0;
            else                key_pressed_r <= key_pressed_r;
        end
    end

    assign col_out     = col_out_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign key_pressed = key_pressed_r;
    assign overrun     = overrun_r;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a physical keypad model drives the rows,
// a sample-level reference model predicts events, a monitor checks them.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
    localparam int T = 4;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_ack = 1'b0;
    logic [3:0] row_in, col_out, key_code;
    logic key_valid, key_pressed, overrun;
    logic [15:0] kp = 16'h0000;  // pressed switches, bit col*4+row
    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { int code; int at; } ev_t;
    ev_t exp_q[$];

    int m_col, m_state, m_crow, m_cnt, m_rpt, m_target, m_code;
    bit m_valid, m_ovr, m_pressed;
    logic valid_q = 1'b0;

    keypad_scan_ctrl #(.SCAN_TICKS(T), .STABLE_SCANS(S)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
        .key_pressed(key_pressed), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A row reads low when a pressed switch joins it to the driven column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_out[c] && kp[c*4+r]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a new code is presented when valid rises or reloads under an ack.
    always @(posedge clk) begin
        ev_t e;
        #3;
        if (rst && key_valid && (!valid_q || key_ack)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: actual=%0h required=none", key_code);
            end else begin
                e = exp_q.pop_front();
                check("event_code", 32'(key_code), 32'(e.code));
                check("event_cycle", 32'(cyc), 32'(e.at));
            end
        end
        valid_q <= rst ? key_valid : 1'b0;
    end

    function automatic logic [3:0] phys_rows(input int col);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) if (kp[col*4+r]) rows[r] = 1'b0;
        return rows;
    endfunction

    task automatic model_reset();
        m_col = 0; m_state = 0; m_crow = 0; m_cnt = 0; m_rpt = 0;
        m_target = 8*S; m_code = 0; m_valid = 0; m_ovr = 0; m_pressed = 0;
    endtask

    // Reference behaviour, one call per sample.
    task automatic model_step(input logic [3:0] rows, input bit ack);
        int lows, idx;
        bit acc;
        lows = 0; idx = 0; acc = 0;
        for (int r = 0; r < 4; r++) if (!rows[r]) begin lows++; idx = r; end
        case (m_state)
            0: if (lows == 1) begin m_crow = idx; m_cnt = 1; m_state = 1; end
               else m_col = (m_col + 1) % 4;
            1: if (lows == 1 && idx == m_crow) begin
                   m_cnt++;
                   if (m_cnt >= S) begin acc = 1; m_state = 2; m_cnt = 0; m_rpt = 0; m_target = 8*S; end
               end else begin
                   m_state = 0; m_col = (m_col + 1) % 4;
               end
            default: begin
                if (rows == 4'hF) begin
                    m_cnt++;
                    if (m_cnt >= S) begin m_pressed = 0; m_state = 0; m_col = (m_col + 1) % 4; end
                end else m_cnt = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                if (lows == 1 && idx == m_crow) begin
                    m_rpt++;
                    if (m_rpt >= m_target) begin acc = 1; m_rpt = 0; m_target = 2*S; end
                end else begin
                    m_rpt = 0; m_target = 8*S;
                end
`endif
            end
        endcase
        if (acc) begin
            m_pressed = 1;
            if (!m_valid || ack) begin
                m_code = m_col*4 + m_crow;
                m_valid = 1;
                exp_q.push_back('{m_code, cyc});
            end else m_ovr = 1;
        end else if (ack) m_valid = 0;
    endtask

    // One scan slot; ack_kind 1 acks mid-slot, 2 acks on the sample edge.
    task automatic slot(input int ack_kind);
        logic [3:0] rows, exp_col;
        rows = phys_rows(m_col);
        for (int c = 0; c < T; c++) begin
            key_ack = (ack_kind == 1 && c == 1) || (ack_kind == 2 && c == T-1);
            @(posedge clk);
            if (ack_kind == 1 && c == 1) m_valid = 0;
            if (c < T-1) @(negedge clk);
        end
        #1;
        model_step(rows, ack_kind == 2);
        exp_col = 4'b0001 << m_col;
        exp_col = ~exp_col;
        check("col_out", 32'(col_out), 32'(exp_col));
        check("key_pressed", 32'(key_pressed), 32'(m_pressed));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) check("key_code", 32'(key_code), 32'(m_code));
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic run_until(input int st, input int max_slots, input int ack_kind, input string name);
        int n;
        n = 0;
        while (m_state != st && n < max_slots) begin slot(ack_kind); n++; end
        total++;
        if (m_state != st) begin
            bad++;
            $display("FAIL %s: state=%0d required=%0d after %0d slots", name, m_state, st, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, 32'(col_out), 32'(4'b1110));
        check({tag, "_code"}, 32'(key_code), 32'(4'h0));
        check({tag, "_valid"}, 32'(key_valid), 32'(1'b0));
        check({tag, "_pressed"}, 32'(key_pressed), 32'(1'b0));
        check({tag, "_overrun"}, 32'(overrun), 32'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        int n;
        int c0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Key 6 (column 1, row 2): accept, then column stays frozen while held.
        kp = 16'h0040;
        run_until(2, 8, 0, "accept_6");
        check("code_6", 32'(key_code), 32'(4'h6));
        check("valid_6", 32'(key_valid), 32'(1'b1));
        for (int i = 0; i < 30; i++) begin
            slot(1);
            check("col_frozen", 32'(col_out), 32'(4'b1101));
        end
        kp = 16'h0000;
        run_until(0, 6, 1, "release_6");
        check("pressed_cleared", 32'(key_pressed), 32'(1'b0));

        // Row 0 bounce during debounce: no event, scanning moves on.
        c0 = m_col;
        kp = 16'h0001 << (c0*4);
        slot(0);
        kp = 16'h0000;
        slot(0);
        check("bounce_next_col", 32'(col_out), 32'(~(4'b0001 << ((c0 + 1) % 4)) & 4'hF));
        kp = 16'h0001 << (c0*4);
        slot(0);
        kp = 16'h0000;
        repeat (2) slot(0);
        check("bounce_no_valid", 32'(key_valid), 32'(1'b0));

        // Two rows low in every column: ignored.
        kp = 16'h9999;
        repeat (8) slot(0);
        kp = 16'h0000;
        check("multi_no_valid", 32'(key_valid), 32'(1'b0));
        check("multi_no_press", 32'(key_pressed), 32'(1'b0));

        // Unacknowledged 6 then B: overrun, old code kept.
        kp = 16'h0040;
        run_until(2, 10, 0, "accept_6b");
        kp = 16'h0000;
        run_until(0, 6, 0, "release_6b");
        kp = 16'h0800;
        run_until(2, 10, 0, "accept_b_ovr");
        check("ovr_code", 32'(key_code), 32'(4'h6));
        check("ovr_flag", 32'(overrun), 32'(1'b1));
        kp = 16'h0000;
        run_until(0, 6, 1, "release_b");

        // Reset in the middle of debounce.
        kp = 16'h0040;
        run_until(1, 8, 0, "enter_debounce");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        kp = 16'h0000;
        check("queue_before_reset", 32'(exp_q.size()), 32'(0));
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("col_after_reset", 32'(col_out), 32'(4'b1110));
        repeat (2) slot(0);

        // Ack on the acceptance cycle: B replaces 6 without overrun.
        kp = 16'h0040;
        run_until(2, 10, 0, "accept_6c");
        kp = 16'h0000;
        run_until(0, 6, 0, "release_6c");
        kp = 16'h0800;
        n = 0;
        while (m_state != 2 && n < 10) begin
            r = phys_rows(m_col);
            slot((m_state == 1 && m_cnt == S-1 && r == (~(4'b0001 << m_crow) & 4'hF)) ? 2 : 0);
            n++;
        end
        check("ackacc_code", 32'(key_code), 32'(4'hB));
        check("ackacc_overrun", 32'(overrun), 32'(1'b0));
        check("ackacc_valid", 32'(key_valid), 32'(1'b1));
        kp = 16'h0000;
        run_until(0, 6, 1, "release_bc");

`ifdef KEYPAD_AUTOREPEAT_EN
        // Held key 0 repeats after 8*S samples, then every 2*S samples.
        kp = 16'h0001;
        run_until(2, 10, 0, "accept_0");
        repeat (40) slot(1);
        kp = 16'h0000;
        run_until(0, 6, 1, "release_0");
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
